// File: rtl/rrv64_ptw_req_arb.sv
// Page-table-walk request arbiter: merges ITLB and DTLB walk requests onto a
// single walker port, keeps at most one walk in flight, routes the response
// back to its owner and handles sfence/satp flushes of the in-flight walk.

package rrv64_ptw_pkg;

  typedef struct packed {
    logic [3:0]  trans_id;
    logic [26:0] vpn;
    logic [1:0]  access_type;
  } rrv64_tlb_ptw_req_t;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        valid;
  } rrv64_pte_t;

  typedef struct packed {
    logic [3:0]  trans_id;
    logic        fault;
    rrv64_pte_t  pte;
  } rrv64_tlb_ptw_resp_t;

  localparam int REQ_W  = $bits(rrv64_tlb_ptw_req_t);
  localparam int RESP_W = $bits(rrv64_tlb_ptw_resp_t);

endpackage

module rrv64_ptw_req_arb
  import rrv64_ptw_pkg::*;
#(
  parameter logic RST_PRIO_DTLB = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              itlb_req_valid,
  input  logic [REQ_W-1:0]  itlb_req,
  output logic              itlb_req_ready,
  input  logic              dtlb_req_valid,
  input  logic [REQ_W-1:0]  dtlb_req,
  output logic              dtlb_req_ready,
  output logic              ptw_req_valid,
  output logic [REQ_W-1:0]  ptw_req,
  input  logic              ptw_req_ready,
  input  logic              ptw_resp_valid,
  input  logic [RESP_W-1:0] ptw_resp,
  output logic              itlb_resp_valid,
  output logic [RESP_W-1:0] itlb_resp,
  input  logic              itlb_resp_ready,
  output logic              dtlb_resp_valid,
  output logic [RESP_W-1:0] dtlb_resp,
  input  logic              dtlb_resp_ready,
  input  logic              flush,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;   // 1: DTLB wins the next tie
  logic               owner_q, owner_d;     // 1: DTLB owns the walk
  logic [REQ_W-1:0]   ptw_req_q;
  logic [RESP_W-1:0]  resp_q;

  logic grant;
  logic pick_dtlb;
  logic capture;
  logic owner_ready;
  logic resp_out_valid;

  // Grant decision: a sole requester wins, a tie goes to rr_ptr.
  always_comb begin
    pick_dtlb = dtlb_req_valid & (~itlb_req_valid | rr_ptr_q);
    grant     = ~rst & (state_q == S_IDLE) & ~flush & (itlb_req_valid | dtlb_req_valid);
  end

  assign owner_ready = owner_q ? dtlb_resp_ready : itlb_resp_ready;
  assign capture     = (state_q == S_WAIT) & ptw_resp_valid & ~flush;

  // Next-state logic for the walk FSM, pointer and owner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d  = S_ISSUE;
          owner_d  = pick_dtlb;
          rr_ptr_d = ~pick_dtlb;
        end
      end
      S_ISSUE: begin
        if (flush)              state_d = ptw_req_ready ? S_DRAIN : S_IDLE;
        else if (ptw_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)               state_d = ptw_resp_valid ? S_IDLE : S_DRAIN;
        else if (ptw_resp_valid) state_d = S_RESP;
      end
      S_RESP: begin
        if (flush || owner_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (ptw_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= RST_PRIO_DTLB;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Payload registers for the walker request and captured response.
  always_ff @(posedge clk) begin
    // NOTE: payloads are qualified by their valids, so they carry no reset.
    if (grant)   ptw_req_q <= pick_dtlb ? dtlb_req : itlb_req;
    if (capture) resp_q    <= ptw_resp;
  end

  assign itlb_req_ready  = grant & ~pick_dtlb;
  assign dtlb_req_ready  = grant & pick_dtlb;

  assign ptw_req_valid   = ~rst & (state_q == S_ISSUE);
  assign ptw_req         = ptw_req_q;

  // A flush in RESP drops the response in the same cycle, so the owner
  // never sees a handshake on a response that is being discarded.
  assign resp_out_valid  = ~rst & (state_q == S_RESP) & ~flush;
  assign itlb_resp_valid = resp_out_valid & ~owner_q;
  assign dtlb_resp_valid = resp_out_valid & owner_q;
  assign itlb_resp       = resp_q;
  assign dtlb_resp       = resp_q;

  assign busy            = ~rst & (state_q != S_IDLE);

endmodule

// File: tb/tb_rrv64_ptw_req_arb.sv
// Scoreboard bench for rrv64_ptw_req_arb: directed stimulus pushes expected
// walker requests and owner responses; a negedge monitor pops and compares
// on every handshake and flags any response raised with nothing expected.

module tb_rrv64_ptw_req_arb;
  import rrv64_ptw_pkg::*;

  typedef struct {
    logic                is_dtlb;
    rrv64_tlb_ptw_resp_t resp;
  } exp_resp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                itlb_req_valid, dtlb_req_valid;
  rrv64_tlb_ptw_req_t  itlb_req, dtlb_req;
  logic                itlb_req_ready, dtlb_req_ready;
  logic                ptw_req_valid, ptw_req_ready;
  logic [REQ_W-1:0]    ptw_req;
  logic                ptw_resp_valid;
  rrv64_tlb_ptw_resp_t ptw_resp;
  logic                itlb_resp_valid, dtlb_resp_valid;
  logic [RESP_W-1:0]   itlb_resp, dtlb_resp;
  logic                itlb_resp_ready, dtlb_resp_ready;
  logic                flush;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  rrv64_tlb_ptw_req_t exp_req_q[$];
  exp_resp_t          exp_resp_q[$];

  always #5 clk = ~clk;

  rrv64_ptw_req_arb #(.RST_PRIO_DTLB(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .itlb_req_valid  (itlb_req_valid),
    .itlb_req        (itlb_req),
    .itlb_req_ready  (itlb_req_ready),
    .dtlb_req_valid  (dtlb_req_valid),
    .dtlb_req        (dtlb_req),
    .dtlb_req_ready  (dtlb_req_ready),
    .ptw_req_valid   (ptw_req_valid),
    .ptw_req         (ptw_req),
    .ptw_req_ready   (ptw_req_ready),
    .ptw_resp_valid  (ptw_resp_valid),
    .ptw_resp        (ptw_resp),
    .itlb_resp_valid (itlb_resp_valid),
    .itlb_resp       (itlb_resp),
    .itlb_resp_ready (itlb_resp_ready),
    .dtlb_resp_valid (dtlb_resp_valid),
    .dtlb_resp       (dtlb_resp),
    .dtlb_resp_ready (dtlb_resp_ready),
    .flush           (flush),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic rrv64_tlb_ptw_req_t mk_req(input logic [3:0] tid, input logic [26:0] vpn,
                                                input logic [1:0] at);
    rrv64_tlb_ptw_req_t r;
    r.trans_id    = tid;
    r.vpn         = vpn;
    r.access_type = at;
    return r;
  endfunction

  function automatic rrv64_tlb_ptw_resp_t mk_resp(input logic [3:0] tid, input logic [43:0] ppn,
                                                  input logic [7:0] flags);
    rrv64_tlb_ptw_resp_t r;
    r             = '0;
    r.trans_id    = tid;
    r.pte.ppn     = ppn;
    {r.pte.d, r.pte.a, r.pte.g, r.pte.u, r.pte.x, r.pte.w, r.pte.r, r.pte.valid} = flags;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input rrv64_tlb_ptw_req_t r);
    exp_req_q.push_back(r);
  endtask

  task automatic push_resp(input logic is_dtlb, input rrv64_tlb_ptw_resp_t r);
    exp_resp_t e;
    e.is_dtlb = is_dtlb;
    e.resp    = r;
    exp_resp_q.push_back(e);
  endtask

  // Monitor: compare every walker-request and owner-response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ptw_req_valid && ptw_req_ready) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_ptw_req", 1'b1, 1'b0);
        end else begin
          rrv64_tlb_ptw_req_t er;
          er = exp_req_q.pop_front();
          check("ptw_req_payload", ptw_req, er);
        end
      end
      if (itlb_resp_valid || dtlb_resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_resp_valid", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
        end else if ((itlb_resp_valid && itlb_resp_ready) || (dtlb_resp_valid && dtlb_resp_ready)) begin
          exp_resp_t e;
          e = exp_resp_q.pop_front();
          check("resp_owner", {itlb_resp_valid, dtlb_resp_valid}, {~e.is_dtlb, e.is_dtlb});
          check("resp_payload", itlb_resp_valid ? itlb_resp : dtlb_resp, e.resp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rrv64_tlb_ptw_resp_t resp_a;
    resp_a = mk_resp(4'd3, 44'h0_0ABC_DEF0, 8'b1100_1011);

    rst = 1'b1; flush = 1'b0;
    itlb_req_valid = 1'b1; dtlb_req_valid = 1'b1;
    itlb_req = mk_req(4'd1, 27'h0_1111, 2'd0);
    dtlb_req = mk_req(4'd2, 27'h0_ABCD, 2'd1);
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp = '0;
    itlb_resp_ready = 1'b0; dtlb_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", {itlb_req_ready, dtlb_req_ready}, 2'b00);
    check("rst_valids", {ptw_req_valid, itlb_resp_valid, dtlb_resp_valid}, 3'b000);
    tick();

    // Tie after reset: DTLB wins.
    rst = 1'b0;
    push_req(dtlb_req);
    ptw_req_ready = 1'b1;
    @(negedge clk);
    check("tie0_ready", {itlb_req_ready, dtlb_req_ready}, 2'b01);
    tick();
    // ISSUE: walker accepts immediately.
    @(negedge clk);
    check("issue_valid", ptw_req_valid, 1'b1);
    check("issue_trans_id", ptw_req[REQ_W-1 -: 4], 4'd2);
    check("issue_no_ready", {itlb_req_ready, dtlb_req_ready}, 2'b00);
    check("issue_busy", busy, 1'b1);
    tick();
    // WAIT: response arrives right away.
    ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp = mk_resp(4'd2, 44'h0_0000_1234, 8'b0000_0111);
    push_resp(1'b1, ptw_resp);
    dtlb_resp_ready = 1'b1;
    @(negedge clk);
    check("wait_no_ptw_valid", ptw_req_valid, 1'b0);
    tick();
    ptw_resp_valid = 1'b0;
    @(negedge clk);
    check("resp_dtlb_only", {itlb_resp_valid, dtlb_resp_valid}, 2'b01);
    tick();

    // Second tie goes to ITLB; this is the vpn 0x12345 / trans_id 3 walk.
    dtlb_resp_ready = 1'b0;
    itlb_req = mk_req(4'd3, 27'h1_2345, 2'd0);
    dtlb_req = mk_req(4'd5, 27'h0_0777, 2'd1);
    push_req(itlb_req);
    @(negedge clk);
    check("tie1_ready", {itlb_req_ready, dtlb_req_ready}, 2'b10);
    tick();
    itlb_req_valid = 1'b0;
    ptw_req_ready = 1'b1;
    @(negedge clk);
    check("n1_ptw_valid", ptw_req_valid, 1'b1);
    tick();
    ptw_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_no_resp", {busy, itlb_resp_valid}, 2'b10);
      tick();
    end
    ptw_resp_valid = 1'b1;
    ptw_resp = resp_a;
    push_resp(1'b0, resp_a);
    @(negedge clk);
    check("n5_not_yet", itlb_resp_valid, 1'b0);
    tick();
    // RESP held for 4 cycles with owner backpressure and DTLB waiting.
    for (int i = 0; i < 4; i++) begin
      ptw_resp_valid = (i == 1);
      ptw_resp = mk_resp(4'd9, 44'hF_FFFF_FFFF, 8'hFF);
      @(negedge clk);
      check("hold_valid", {itlb_resp_valid, dtlb_resp_valid}, 2'b10);
      check("hold_payload", itlb_resp, resp_a);
      check("hold_no_grant", dtlb_req_ready, 1'b0);
      tick();
    end
    ptw_resp_valid = 1'b0;
    itlb_resp_ready = 1'b1;
    @(negedge clk);
    check("release_valid", itlb_resp_valid, 1'b1);
    tick();

    // DTLB sole request; flush in WAIT, response 3 cycles later is dropped.
    itlb_resp_ready = 1'b0;
    push_req(dtlb_req);
    @(negedge clk);
    check("sole_dtlb_ready", {itlb_req_ready, dtlb_req_ready}, 2'b01);
    tick();
    dtlb_req_valid = 1'b0;
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_wait_busy", busy, 1'b1);
    tick();
    flush = 1'b0;
    itlb_resp_ready = 1'b1;
    dtlb_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_busy", busy, 1'b1);
      tick();
    end
    ptw_resp_valid = 1'b1;
    ptw_resp = mk_resp(4'd5, 44'h0_0000_0555, 8'b0000_0001);
    itlb_req = mk_req(4'd6, 27'h0_0066, 2'd2);
    itlb_req_valid = 1'b1;
    @(negedge clk);
    check("drain_resp_busy", busy, 1'b1);
    check("drain_no_grant", itlb_req_ready, 1'b0);
    check("drain_no_resp", dtlb_resp_valid, 1'b0);
    tick();
    ptw_resp_valid = 1'b0;
    push_req(itlb_req);
    @(negedge clk);
    check("post_drain_idle", busy, 1'b0);
    check("post_drain_grant", {itlb_req_ready, dtlb_req_ready}, 2'b10);
    tick();

    // Flush coincident with walker accept in ISSUE -> DRAIN.
    itlb_req_valid = 1'b0;
    flush = 1'b1;
    ptw_req_ready = 1'b1;
    @(negedge clk);
    check("issue_flush_valid", ptw_req_valid, 1'b1);
    tick();
    flush = 1'b0;
    ptw_req_ready = 1'b0;
    @(negedge clk);
    check("issue_flush_drain", {busy, ptw_req_valid}, 2'b10);
    tick();
    ptw_resp_valid = 1'b1;
    ptw_resp = mk_resp(4'd6, 44'h0_0000_0666, 8'b0000_0001);
    @(negedge clk);
    check("drain2_busy", {busy, itlb_resp_valid}, 2'b10);
    tick();

    // Flush in IDLE suppresses the grant; flush in ISSUE without accept -> IDLE.
    ptw_resp_valid = 1'b0;
    dtlb_req = mk_req(4'd7, 27'h7_7777, 2'd1);
    dtlb_req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("idle_flush_busy", busy, 1'b0);
    check("idle_flush_no_grant", dtlb_req_ready, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("grant_after_flush", dtlb_req_ready, 1'b1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("issue_flush_noacc", ptw_req_valid, 1'b1);
    tick();
    flush = 1'b0;
    push_req(dtlb_req);
    @(negedge clk);
    check("issue_flush_idle", busy, 1'b0);
    check("regrant_dtlb", dtlb_req_ready, 1'b1);
    tick();

    // Reset while in RESP abandons the walk.
    dtlb_req_valid = 1'b0;
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    dtlb_resp_ready = 1'b0;
    itlb_resp_ready = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp = mk_resp(4'd7, 44'h0_0000_0777, 8'b0000_0011);
    push_resp(1'b1, ptw_resp);
    tick();
    ptw_resp_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_resp", dtlb_resp_valid, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_outputs", {dtlb_resp_valid, busy}, 2'b00);
    tick();
    rst = 1'b0;
    exp_resp_q.delete();
    dtlb_resp_ready = 1'b1;
    ptw_resp_valid = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {busy, dtlb_resp_valid, itlb_resp_valid}, 3'b000);
    tick();
    ptw_resp_valid = 1'b0;
    itlb_req_valid = 1'b1;
    dtlb_req_valid = 1'b1;
    @(negedge clk);
    check("late_resp_ignored", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
    check("rr_after_rst", {itlb_req_ready, dtlb_req_ready}, 2'b01);
    tick();

    itlb_req_valid = 1'b0;
    dtlb_req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("req_queue_empty", exp_req_q.size(), 0);
    check("resp_queue_empty", exp_resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rrv64_ptw_req_arb.md
RRV64_PTW_REQ_ARB -- requirements
Module: rrv64_ptw_req_arb

Interface
REQ-001 The block SHALL have parameter RST_PRIO_DTLB, default 1, meaning round-robin pointer reset value (1 = DTLB wins first tie, 0 = ITLB).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports itlb_req_valid / dtlb_req_valid  input  1  requester has a walk request.
REQ-005 The block SHALL have ports itlb_req / dtlb_req  input  $bits(rrv64_tlb_ptw_req_t)  trans_id, vpn, access_type.
REQ-006 The block SHALL have ports itlb_req_ready / dtlb_req_ready  output  1  request accepted this cycle.
REQ-007 The block SHALL have ports ptw_req_valid output 1, ptw_req output $bits(rrv64_tlb_ptw_req_t), ptw_req_ready input 1  shared walker request channel.
REQ-008 The block SHALL have ports ptw_resp_valid input 1, ptw_resp input $bits(rrv64_tlb_ptw_resp_t)  walker response; the walker does not accept backpressure.
REQ-009 The block SHALL have ports itlb_resp_valid / dtlb_resp_valid output 1, itlb_resp / dtlb_resp output $bits(rrv64_tlb_ptw_resp_t), itlb_resp_ready / dtlb_resp_ready input 1.
REQ-010 The block SHALL have port flush  input  1  sfence.vma / satp change; kills the in-flight walk.
REQ-011 The block SHALL have port busy  output  1  state != IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP and DRAIN, with one walk outstanding at most.
REQ-013 In IDLE with flush=0, a grant SHALL be made when at least one req_valid is set: a sole valid wins; on a tie the requester indicated by rr_ptr wins.
REQ-014 The granted requester's req_ready SHALL be asserted combinationally in the grant cycle; the other req_ready SHALL be 0; outside IDLE both SHALL be 0.
REQ-015 On grant, the block SHALL register the request into ptw_req, record owner, toggle rr_ptr to the non-winner, and enter ISSUE the next cycle.
REQ-016 In ISSUE, ptw_req_valid SHALL be 1 with ptw_req stable; on ptw_req_ready=1 the FSM SHALL go to WAIT.
REQ-017 In WAIT, on ptw_resp_valid=1 the block SHALL capture ptw_resp and go to RESP.
REQ-018 In RESP, the owner's resp_valid SHALL be 1 with the captured response, which is held unchanged; on owner resp_ready=1 the FSM SHALL return to IDLE.
REQ-019 The block SHALL copy trans_id unchanged from request to response, with no renaming.
REQ-020 The minimum latency SHALL be: grant at cycle N, ptw_req_valid at N+1; ptw_resp_valid at cycle M, owner resp_valid at M+1.
REQ-021 Flush SHALL be handled per state: in IDLE it suppresses any grant; in ISSUE it goes to IDLE, unless ptw_req_ready=1 in the same cycle, which goes to DRAIN; in WAIT it goes to DRAIN, or to IDLE with the response discarded if ptw_resp_valid=1 in the same cycle; in RESP it goes to IDLE with resp_valid deasserted and the response dropped; in DRAIN it is ignored.
REQ-022 In DRAIN, the block SHALL wait for ptw_resp_valid, discard the response, and then go to IDLE; no resp_valid SHALL be raised.
REQ-023 When ptw_resp_valid=1 occurs in IDLE, ISSUE or RESP, the block SHALL ignore it.
REQ-024 resp_valid SHALL never be asserted to the non-owner requester.

Reset
REQ-025 While rst=1 the block SHALL set state=IDLE and rr_ptr=RST_PRIO_DTLB, and drive all valid and ready outputs and busy to 0.
REQ-026 Reset asserted mid-walk SHALL abandon the walk with no response delivered; the walker is reset together with this block.
REQ-027 Registered payloads (ptw_req, response buffer) SHALL have no reset requirement; they are don't-care while the associated valid is 0.

Verification
REQ-028 Reset, then both req_valid=1 with RST_PRIO_DTLB=1 -> dtlb_req_ready=1 and itlb_req_ready=0 in cycle 0; ptw_req.trans_id equals dtlb_req.trans_id at cycle 1; the next tie goes to ITLB.
REQ-029 ITLB request with vpn=0x12345 and trans_id=3; ptw_req_ready=1 at cycle 1; ptw_resp_valid at cycle 5 with trans_id=3 and pte.valid=1 -> itlb_resp_valid=1 at cycle 6 with identical fields; dtlb_resp_valid stays 0.
REQ-030 Owner holds resp_ready=0 for 4 cycles -> itlb_resp_valid held and payload stable for 4 cycles; no grant while in RESP even with dtlb_req_valid=1.
REQ-031 Flush in WAIT, then walker response 3 cycles later -> no resp_valid; busy=1 until the cycle after the response, then the next grant.
REQ-032 Flush in the same cycle as ptw_req_ready=1 in ISSUE -> DRAIN entered; the subsequent response is discarded.
REQ-033 rst asserted in RESP -> the next cycle shows all valids at 0 and state IDLE; a late ptw_resp_valid is ignored.
